// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, 1-2 stop bits; Tx is a flop.
// Start bit appears the cycle after the valid/ready handshake; tx_ready is high only while idle.
module uart_tx #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       Tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int CPB = CLK_FREQ_HZ / BAUD;
    localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam bit P_EN = (PARITY == 1) || (PARITY == 2);
    localparam int STOPS = (STOP_BITS == 2) ? 2 : 1;
    localparam logic [2:0] STOP_LAST = 3'(STOPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_par;
    logic          r_tx;
    logic          r_done;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    w_shift_nxt;
    logic          w_par_nxt;
    logic          w_tx_nxt;
    logic          w_done_nxt;
    logic          w_bit_end;

    assign w_bit_end = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= w_tx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // The line value for the next bit is decided here so Tx changes only at bit boundaries.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_tx_nxt    = r_tx;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_tx_nxt  = 1'b1;
                if (tx_valid) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = tx_data;
                    w_par_nxt   = (PARITY == 1) ? ~^tx_data : ^tx_data;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_bit_nxt = '0;
                        if (P_EN) begin
                            w_state_nxt = S_PARITY;
                            w_tx_nxt    = r_par;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = 1'b1;
                end
            end
            S_STOP: begin
                // r_bit counts stop bits here so the baud counter never exceeds one bit time.
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_bit == STOP_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_bit_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_bit_nxt   = '0;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    assign tx_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign Tx       = r_tx;
    assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three parity/stop configurations at 10 clocks per bit, checked cycle by cycle.
module tb_uart_tx;
    localparam int C = 10;

    logic       clk = 1'b0;
    logic       RST;
    logic [2:0] vld;
    logic [7:0] dat [3];
    logic [2:0] rdy;
    logic [2:0] txl;
    logic [2:0] bsy;
    logic [2:0] dn;
    logic [15:0] mid;
    logic [7:0] b;
    logic [7:0] nb;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ_HZ(1000), .BAUD(100), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .RST(RST), .tx_data(dat[0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .Tx(txl[0]), .busy(bsy[0]), .tx_done(dn[0]));
    uart_tx #(.CLK_FREQ_HZ(1000), .BAUD(100), .PARITY(2), .STOP_BITS(2)) u1 (
        .clk(clk), .RST(RST), .tx_data(dat[1]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .Tx(txl[1]), .busy(bsy[1]), .tx_done(dn[1]));
    uart_tx #(.CLK_FREQ_HZ(1000), .BAUD(100), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .RST(RST), .tx_data(dat[2]), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .Tx(txl[2]), .busy(bsy[2]), .tx_done(dn[2]));

    function automatic int par_mode(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 1);
    endfunction

    function automatic int stop_cnt(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int d);
        return (1 + 8 + ((par_mode(d) != 0) ? 1 : 0) + stop_cnt(d)) * C;
    endfunction

    // Expected line level t cycles after the handshake edge (t = 1 is the first start-bit cycle).
    function automatic logic model_tx(input int d, input logic [7:0] v, input int t);
        int slot;
        int ones;
        slot = (t - 1) / C;
        ones = $countones(v);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return v[slot-1];
        if (slot == 9 && par_mode(d) != 0)
            return (par_mode(d) == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_frame(input int d, input logic [7:0] v, input bit chain,
                            input logic [7:0] nv, output logic [15:0] m);
        int len;
        len = frame_len(d);
        m = '0;
        dat[d] = v;
        vld[d] = 1'b1;
        chk("ready_before", 32'(rdy[d]), 32'd1);
        tick();
        if (chain) begin
            dat[d] = nv;
        end else begin
            vld[d] = 1'b0;
            dat[d] = 8'($urandom);
        end
        for (int t = 1; t <= len; t++) begin
            chk("tx_bit", 32'(txl[d]), 32'(model_tx(d, v, t)));
            chk("busy_in_frame", 32'(bsy[d]), 32'd1);
            chk("no_done_in_frame", 32'(dn[d]), 32'd0);
            if ((t - 1) % C == C / 2) m[(t-1)/C] = txl[d];
            tick();
        end
        chk("done_pulse", 32'(dn[d]), 32'd1);
        chk("ready_at_end", 32'(rdy[d]), 32'd1);
        chk("busy_at_end", 32'(bsy[d]), 32'd0);
        chk("idle_high", 32'(txl[d]), 32'd1);
        if (!chain) begin
            tick();
            chk("done_one_cycle", 32'(dn[d]), 32'd0);
            chk("idle_high_after", 32'(txl[d]), 32'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1;
        vld = 3'b111;
        for (int i = 0; i < 3; i++) dat[i] = 8'h5A;

        // Reset held with valid asserted: nothing may start.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_tx", 32'(txl), 32'h7);
            chk("rst_ready", 32'(rdy), 32'h7);
            chk("rst_busy", 32'(bsy), 32'h0);
            chk("rst_done", 32'(dn), 32'h0);
        end
        RST = 1'b0;
        vld = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_tx", 32'(txl), 32'h7);
            chk("post_rst_ready", 32'(rdy), 32'h7);
            chk("post_rst_busy", 32'(bsy), 32'h0);
            chk("post_rst_done", 32'(dn), 32'h0);
        end

        // Single byte 0xA5, 8N1.
        do_frame(0, 8'hA5, 1'b0, 8'h00, mid);
        chk("a5_midbits", 32'(mid[9:0]), 32'b1101001010);

        // Back-to-back 0x00 then 0xFF with valid held high.
        do_frame(0, 8'h00, 1'b1, 8'hFF, mid);
        chk("b2b_zero_bits", 32'(mid[8:1]), 32'h00);
        do_frame(0, 8'hFF, 1'b0, 8'h00, mid);
        chk("b2b_ones_bits", 32'(mid[8:1]), 32'hFF);

        // Parity configurations with byte 0x07.
        do_frame(1, 8'h07, 1'b0, 8'h00, mid);
        chk("even_parity_bit", 32'(mid[9]), 32'd1);
        chk("two_stop_bits", 32'(mid[11:10]), 32'h3);
        do_frame(2, 8'h07, 1'b0, 8'h00, mid);
        chk("odd_parity_bit", 32'(mid[9]), 32'd0);

        // Random byte chains on each configuration.
        for (int d = 0; d < 3; d++) begin
            b = 8'($urandom);
            for (int n = 0; n < 4; n++) begin
                nb = 8'($urandom);
                do_frame(d, b, (n < 3), nb, mid);
                b = nb;
            end
        end

        // Reset 45 cycles into a frame aborts it.
        dat[0] = 8'hB6;
        vld[0] = 1'b1;
        tick();
        vld[0] = 1'b0;
        for (int t = 1; t < 45; t++) begin
            chk("pre_abort_tx", 32'(txl[0]), 32'(model_tx(0, 8'hB6, t)));
            tick();
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("abort_tx", 32'(txl[0]), 32'd1);
        chk("abort_ready", 32'(rdy[0]), 32'd1);
        chk("abort_busy", 32'(bsy[0]), 32'd0);
        chk("abort_done", 32'(dn[0]), 32'd0);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("abort_no_done", 32'(dn[0]), 32'd0);
            chk("abort_idle_tx", 32'(txl[0]), 32'd1);
        end
        do_frame(0, 8'h3C, 1'b0, 8'h00, mid);
        chk("after_abort_bits", 32'(mid[9:0]), 32'({1'b1, 8'h3C, 1'b0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
